// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register countdown scoreboard for the in-order pipeline.
// Sits beside ID. It stalls an instruction whose source operand is still
// pending, and records a countdown for every destination write it issues.
// Optional build macro SCOREBOARD_STATS_EN adds stall_cycles and
// load_use_stalls counters, and a per-register "marked by a load" tag.
module pipe_scoreboard #(
    parameter int NREG     = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic              id_rs_used,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic              issue,
`ifdef SCOREBOARD_STATS_EN
    output logic [NREG-1:0]   busy,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       load_use_stalls
`else
    output logic [NREG-1:0]   busy
`endif
);

    localparam logic [CNT_W-1:0] ALU_L  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_LAT);

    // Entry 0 is kept at constant zero so the hardwired-zero register never
    // looks pending; synthesis folds it away.
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_dec [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];

    logic             rs_blk;
    logic             rt_blk;
    logic             haz;
    logic             mark;
    logic [CNT_W-1:0] mark_lat;

    // Source operand lookup: a source blocks only if it is read, non-zero,
    // in range and its entry is still counting.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rs_blk = 1'b0;
        rt_blk = 1'b0;
        if (id_rs_used && id_rs != '0 && int'(id_rs) < NREG)
            rs_blk = (cnt[id_rs] != '0);
        if (id_rt_used && id_rt != '0 && int'(id_rt) < NREG)
            rt_blk = (cnt[id_rt] != '0);
    end

    assign haz   = rs_blk | rt_blk;
    assign stall = id_valid & ~flush & (haz | freeze);
    assign issue = id_valid & ~flush & ~stall;

    assign mark_lat = id_is_load ? LOAD_L : ALU_L;
    // A zero latency needs no tracking, so such producers leave the entry alone.
    assign mark = issue & id_wr_en & (id_rd != '0) & (int'(id_rd) < NREG)
                & (mark_lat != '0);

    // Countdown of every entry, then the destination mark. The mark takes the
    // larger of the new latency and the decremented count so a younger write
    // never hides an older, slower one (WAW).
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_dec[r] = cnt[r];
            if (r == 0)
                cnt_dec[r] = '0;
            else if (!freeze && cnt[r] != '0)
                cnt_dec[r] = cnt[r] - CNT_W'(1);
            cnt_nxt[r] = cnt_dec[r];
            if (mark && int'(id_rd) == r && mark_lat > cnt_dec[r])
                cnt_nxt[r] = mark_lat;
        end
    end

    // Counter state; reset clears every entry and wins over all other inputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge, never from each other.
        if (reset) begin
            // NOTE: this array is reset explicitly because a stale count after
            // reset would stall the pipeline on a phantom producer.
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
        end
    end

    // busy mirrors the registered counters; register 0 never reports busy.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++)
            busy[r] = (cnt[r] != '0);
    end

`ifdef SCOREBOARD_STATS_EN
    logic [NREG-1:0] is_load;
    logic [NREG-1:0] is_load_nxt;
    logic            rs_tag;
    logic            rt_tag;
    logic            load_use;

    // Tag of the entry that is blocking each source.
    always_comb begin
        rs_tag = 1'b0;
        rt_tag = 1'b0;
        if (rs_blk)
            rs_tag = is_load[id_rs];
        if (rt_blk)
            rt_tag = is_load[id_rt];
    end

    assign load_use = stall & ~freeze & (rs_tag | rt_tag);

    // Tag follows whichever producer owns the count; cleared once it drains.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            is_load_nxt[r] = is_load[r];
            if (mark && int'(id_rd) == r && mark_lat > cnt_dec[r])
                is_load_nxt[r] = id_is_load;
            if (cnt_nxt[r] == '0)
                is_load_nxt[r] = 1'b0;
        end
    end

    // Load tags and the two free-running (wrapping) statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_load         <= '0;
            stall_cycles    <= '0;
            load_use_stalls <= '0;
        end else begin
            is_load <= is_load_nxt;
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
            if (load_use)
                load_use_stalls <= load_use_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed scenarios plus random
// traffic, checked by a scoreboard fed from a ready-time reference model.
module tb_pipe_scoreboard;

    localparam int NREG     = 24;
    localparam int REG_AW   = 5;
    localparam int ALU_LAT  = 2;
    localparam int LOAD_LAT = 4;
    localparam int CNT_W    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic              id_rs_used;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr_en;
    logic              id_is_load;
    logic              flush;
    logic              freeze;
    logic              stall;
    logic              issue;
    logic [NREG-1:0]   busy;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       load_use_stalls;
`endif

    pipe_scoreboard #(
        .NREG(NREG), .REG_AW(REG_AW), .ALU_LAT(ALU_LAT),
        .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .flush(flush), .freeze(freeze),
        .stall(stall), .issue(issue),
`ifdef SCOREBOARD_STATS_EN
        .busy(busy),
        .stall_cycles(stall_cycles),
        .load_use_stalls(load_use_stalls)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        rst, v, rs_u, rt_u, wr, ld, fl, fz;
        bit [4:0]  rs, rt, rd;
    } stim_t;

    typedef struct {
        bit              stall, issue, lu;
        logic [NREG-1:0] busy;
        int unsigned     sc, lus;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a register is forwardable once the count of unfrozen
    // clock edges t reaches its ready time.
    int          t;
    int          ready[NREG];
    bit          ld_tag[NREG];
    int unsigned m_sc, m_lus;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit blocks(input bit used, input bit [4:0] idx);
        return used && idx != 0 && int'(idx) < NREG && ready[idx] > t;
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit haz, lu_src;
        haz      = blocks(s.rs_u, s.rs) || blocks(s.rt_u, s.rt);
        lu_src   = (blocks(s.rs_u, s.rs) && ld_tag[s.rs]) || (blocks(s.rt_u, s.rt) && ld_tag[s.rt]);
        e.stall  = s.v && !s.fl && (haz || s.fz);
        e.issue  = s.v && !s.fl && !e.stall;
        e.lu     = e.stall && !s.fz && lu_src;
        e.busy   = '0;
        for (int r = 1; r < NREG; r++) e.busy[r] = (ready[r] > t);
        e.sc     = m_sc;
        e.lus    = m_lus;
        return e;
    endfunction

    function automatic void advance(input stim_t s, input exp_t e);
        int lat, nr;
        if (s.rst) begin
            t = 0; m_sc = 0; m_lus = 0;
            for (int r = 0; r < NREG; r++) begin ready[r] = 0; ld_tag[r] = 0; end
            return;
        end
        if (e.stall) m_sc++;
        if (e.lu) m_lus++;
        if (s.fz) return;
        lat = s.ld ? LOAD_LAT : ALU_LAT;
        if (e.issue && s.wr && s.rd != 0 && int'(s.rd) < NREG && lat > 0) begin
            nr = t + 1 + lat;
            if (nr > ready[s.rd]) begin ready[s.rd] = nr; ld_tag[s.rd] = s.ld; end
        end
        t++;
    endfunction

    // One cycle: drive, queue the expectation, sample stall mid-cycle, clock.
    task automatic step(input stim_t s, input bit chk, output bit dut_stall);
        exp_t e;
        reset = s.rst; id_valid = s.v; id_rs = s.rs; id_rs_used = s.rs_u;
        id_rt = s.rt; id_rt_used = s.rt_u; id_rd = s.rd; id_wr_en = s.wr;
        id_is_load = s.ld; flush = s.fl; freeze = s.fz;
        e = predict(s);
        if (chk) exp_q.push_back(e);
        #3;
        dut_stall = stall;
        @(posedge clk);
        advance(s, e);
        #1;
    endtask

    task automatic writer(input bit [4:0] rd, input bit ld);
        stim_t s; bit st;
        s = '0; s.v = 1; s.wr = 1; s.rd = rd; s.ld = ld;
        step(s, 1, st);
    endtask

    // Present a reader of rs until it issues; compare observed stall length.
    task automatic hold_reader(input string name, input bit [4:0] rs, input bit used, input int exp_n);
        stim_t s; bit st; int n;
        s = '0; s.v = 1; s.rs = rs; s.rs_u = used;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(s, 1, st);
            if (!st) break;
            n++;
        end
        check(name, n, exp_n);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall", stall, e.stall);
            check("issue", issue, e.issue);
            check("busy", busy, e.busy);
`ifdef SCOREBOARD_STATS_EN
            check("stall_cycles", stall_cycles, e.sc);
            check("load_use_stalls", load_use_stalls, e.lus);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        bit st;
        t = 0; m_sc = 0; m_lus = 0;
        for (int r = 0; r < NREG; r++) begin ready[r] = 0; ld_tag[r] = 0; end
        reset = 1; id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
        id_rd = 0; id_wr_en = 0; id_is_load = 0; flush = 0; freeze = 0;
        @(posedge clk); #1;

        // Reset: first cycle state is unknown, second is checked.
        s = '0; s.rst = 1;
        step(s, 0, st);
        step(s, 1, st);

        // ALU producer then dependent reader; load producer then reader.
        writer(5'd3, 1'b0);
        hold_reader("alu_use_stalls", 5'd3, 1'b1, ALU_LAT);
        writer(5'd3, 1'b1);
        hold_reader("load_use_stalls_len", 5'd3, 1'b1, LOAD_LAT);

        // WAW: ALU write one cycle after a load must not shorten the count.
        writer(5'd7, 1'b1);
        writer(5'd7, 1'b0);
        hold_reader("waw_keeps_load", 5'd7, 1'b1, LOAD_LAT - 1);

        // Freeze holds the count and stalls throughout.
        writer(5'd9, 1'b1);
        s = '0; s.v = 1; s.rs = 9; s.rs_u = 1; s.fz = 1;
        for (int k = 0; k < 5; k++) step(s, 1, st);
        hold_reader("freeze_resume", 5'd9, 1'b1, LOAD_LAT);

        // Register zero and unused operands never stall.
        writer(5'd0, 1'b1);
        hold_reader("r0_no_stall", 5'd0, 1'b1, 0);
        writer(5'd2, 1'b1);
        hold_reader("unused_rs_no_stall", 5'd2, 1'b0, 0);
        s = '0; s.v = 1; s.rs = 5'd30; s.rs_u = 1;
        step(s, 1, st);

        // Reset mid-stall clears everything.
        writer(5'd4, 1'b1);
        s = '0; s.v = 1; s.rs = 4; s.rs_u = 1;
        step(s, 1, st);
        s.rst = 1;
        step(s, 1, st);
        hold_reader("reset_mid_stall", 5'd4, 1'b1, 0);

        // Random traffic, biased towards a few low registers to create hazards.
        for (int k = 0; k < 3000; k++) begin
            s      = '0;
            s.rst  = ($urandom_range(0, 199) == 0);
            s.v    = ($urandom_range(0, 7) != 0);
            s.rs_u = $urandom_range(0, 1);
            s.rt_u = $urandom_range(0, 1);
            s.wr   = ($urandom_range(0, 3) != 0);
            s.ld   = ($urandom_range(0, 4) < 2);
            s.fl   = ($urandom_range(0, 9) == 0);
            s.fz   = ($urandom_range(0, 9) == 0);
            s.rs   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            s.rt   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            s.rd   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step(s, 1, st);
        end

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
Parametrised register scoreboard for the in-order pipeline. It replaces the fixed load-use hazard detector with per-register countdown tracking, so the pipeline can support configurable ALU and load latencies and any register count. It sits beside the ID stage. It observes each instruction being issued from ID to EX, asserts stall/PCWrite-hold when a source operand is not yet forwardable, and records pending destination writes.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked
REG_AW, 5, register index width; must satisfy 2**REG_AW >= NREG
ALU_LAT, 0, stall cycles a directly following dependent instruction needs after an ALU producer (0 = fully forwarded)
LOAD_LAT, 1, stall cycles a directly following dependent instruction needs after a load producer
CNT_W, 3, counter width; must hold max(ALU_LAT, LOAD_LAT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction this cycle
id_rs  in  REG_AW  source register 1 index
id_rs_used  in  1  instruction reads rs
id_rt  in  REG_AW  source register 2 index
id_rt_used  in  1  instruction reads rt
id_rd  in  REG_AW  destination register index
id_wr_en  in  1  instruction writes rd
id_is_load  in  1  producer is a load (selects LOAD_LAT), else ALU_LAT
flush  in  1  branch flush: ID instruction is squashed this cycle
freeze  in  1  global pipeline freeze (memory wait); EX/MEM/WB do not advance
stall  out  1  ID must hold; PC write disabled; bubble inserted into EX
issue  out  1  ID instruction accepted into EX this cycle
busy  out  NREG  bit r set when cnt[r] != 0; bit 0 always 0

Behaviour:
- State: cnt[r] of CNT_W bits for r = 1..NREG-1. cnt[0] does not exist and is read as 0.
- Reset (synchronous, clk edge with reset=1): all cnt cleared. busy = 0. Reset has priority over every other input, including when applied mid-stall.
- Hazard (combinational from current cnt and inputs, 0-cycle latency):
  - haz = (id_rs_used & id_rs!=0 & cnt[id_rs]!=0) | (id_rt_used & id_rt!=0 & cnt[id_rt]!=0).
  - Out-of-range indices (>= NREG) are treated as cnt=0.
- Output equations:
  - stall = id_valid & ~flush & (haz | freeze).
  - issue = id_valid & ~flush & ~stall.
- Countdown: on each clk edge with freeze=0, every nonzero cnt decrements by 1. With freeze=1, all cnt hold.
- Mark: on an edge with issue=1, id_wr_en=1, id_rd!=0, id_rd<NREG, L = id_is_load ? LOAD_LAT : ALU_LAT.
  - cnt[id_rd] <= max(L, dec(cnt[id_rd])), where dec is the value after this edge's countdown (WAW never shortens an older pending write).
  - L=0 leaves the entry unmarked.
- Simultaneous mark and countdown on the same register: the mark rule above applies; other registers count down normally.
- Reading and writing the same register (e.g. rs==rd): the hazard check uses cnt before the mark, so an instruction never stalls on itself.
- flush=1: no issue, no mark, stall=0. Countdown continues (unless freeze).
- Stalled instruction: no mark. It re-evaluates every cycle until issue.
- busy is derived from registered cnt (registered-output timing).
- Counters saturate at 0; no wrap-around below 0.

Optional Feature:
Macro SCOREBOARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and load_use_stalls[31:0], both cleared by reset.
  - stall_cycles increments on every cycle with stall=1.
  - load_use_stalls increments on cycles where stall=1, freeze=0, and the blocking source entry was marked by a load. This needs one per-register is_load tag bit, cleared when cnt reaches 0.
  - Both counters wrap at 2**32.
- Undefined: no counters, no tag bits, no extra ports. Core behaviour is identical in both builds.

Test Plan:
- Defaults. Load issues to r5, next instruction reads rs=r5 → stall=1 for exactly 1 cycle, then issue=1. busy[5]=1 for 1 cycle.
- ALU_LAT=2, LOAD_LAT=4. ALU to r3 followed by a reader of r3 → 2 stall cycles. Load to r3 followed by a reader of r3 → 4 stall cycles.
- LOAD_LAT=4. Load to r7, then 1 cycle later an ALU (ALU_LAT=1) to r7 (WAW), then a reader of r7 → cnt[7] keeps the load's remaining count (3). Reader stalls until cnt[7]=0; it is not released after 1 cycle.
- Load to r9 with freeze=1 held for 5 cycles → cnt[9] holds and stall=1 throughout. After freeze drops, countdown resumes from the held value.
- id_rd=0 load, reader of r0 → no stall, busy=0. Reader with rs=r2 but rs_used=0 while busy[2]=1 → no stall.
- reset asserted mid-stall with cnt[4]=3 → next cycle busy=0, stall=0. With SCOREBOARD_STATS_EN, both counters read 0.
